alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 137 +++++++++++++
 tb/tb_alu_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Two-port round-robin front end for a shared ALU with an external iterative multiplier.
// The scheduler grants one requester, drives the ALU operands, waits for the result and reports it.
module alu_scheduler #(
    parameter int TIMEOUT = 600
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [15:0] alu_Rout,
    input  logic        mul_done,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        err,
    output logic        busy,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [1:0]  alu_op,
    output logic        mul_start
);

    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]      OP_MUL   = 2'd2;

    typedef enum logic [1:0] {IDLE, EXEC, MULWAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          owner;       // 1: port1 holds the current operation
    logic          last_owner;  // port served most recently
    logic          timed_out;

    logic          sel_port1;
    logic [1:0]    sel_op;
    logic [15:0]   sel_a;
    logic [15:0]   sel_b;

    // Port1 wins when it is the only requester, or on a tie when port0 was served last.
    always_comb begin
        sel_port1 = req1 && (!req0 || !last_owner);
        sel_op    = sel_port1 ? op1 : op0;
        sel_a     = sel_port1 ? a1  : a0;
        sel_b     = sel_port1 ? b1  : b0;
    end

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            timed_out  <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            result     <= 16'h0000;
            alu_A      <= 16'h0000;
            alu_B      <= 16'h0000;
            alu_op     <= 2'b00;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt0      <= !sel_port1;
                        gnt1      <= sel_port1;
                        owner     <= sel_port1;
                        timed_out <= 1'b0;
                        alu_op    <= sel_op;
                        // The multiplier only consumes the low operand bytes.
                        alu_A     <= (sel_op == OP_MUL) ? {8'h00, sel_a[7:0]} : sel_a;
                        alu_B     <= (sel_op == OP_MUL) ? {8'h00, sel_b[7:0]} : sel_b;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_op == OP_MUL) begin
                        mul_start <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= MULWAIT;
                    end else begin
                        result <= alu_Rout;
                        state  <= RESP;
                    end
                end
                MULWAIT: begin
                    // A completion arriving on the final wait cycle still beats the timeout.
                    if (mul_done) begin
                        result <= alu_Rout;
                        state  <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        result    <= 16'h0000;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    done0      <= !owner;
                    done1      <= owner;
                    err        <= timed_out;
                    timed_out  <= 1'b0;
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: a transaction timeline model predicts every output each cycle;
// a second instance with a short timeout exercises the multiply timeout path.
module tb_alu_scheduler;

    localparam int TA = 16;
    localparam int TT = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    always #5 Clk = ~Clk;

    // main instance
    logic        rq [2];
    logic [1:0]  rop [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic [15:0] alu_Rout;
    logic        mul_done;
    logic        gnt0, gnt1, done0, done1, err, busy, mul_start;
    logic [15:0] result, alu_A, alu_B;
    logic [1:0]  alu_op;
    logic [15:0] noise;

    // timeout instance
    logic        t_req0, t_mul_done;
    logic [1:0]  t_op0;
    logic [15:0] t_a0, t_b0, t_rout;
    logic        t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_busy, t_mul_start;
    logic [15:0] t_result, t_alu_A, t_alu_B;
    logic [1:0]  t_alu_op;

    alu_scheduler #(.TIMEOUT(TA)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0(rq[0]), .req1(rq[1]), .op0(rop[0]), .op1(rop[1]),
        .a0(ra[0]), .b0(rb[0]), .a1(ra[1]), .b1(rb[1]),
        .alu_Rout(alu_Rout), .mul_done(mul_done),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .mul_start(mul_start)
    );

    alu_scheduler #(.TIMEOUT(TT)) dut_t (
        .Clk(Clk), .Rst(Rst),
        .req0(t_req0), .req1(1'b0), .op0(t_op0), .op1(2'b00),
        .a0(t_a0), .b0(t_b0), .a1(16'h0000), .b1(16'h0000),
        .alu_Rout(t_rout), .mul_done(t_mul_done),
        .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1),
        .result(t_result), .err(t_err), .busy(t_busy),
        .alu_A(t_alu_A), .alu_B(t_alu_B), .alu_op(t_alu_op), .mul_start(t_mul_start)
    );

    function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0000, a} * {16'h0000, b};
        case (op)
            2'd0:    return a | b;
            2'd1:    return a + b;
            2'd2:    return p[15:0];
            default: return ~a;
        endcase
    endfunction

    // Shared ALU: a multiply product is only presented while the multiplier reports done.
    always_comb begin
        if (alu_op == 2'd2 && !mul_done) alu_Rout = noise;
        else                             alu_Rout = alu_fn(alu_op, alu_A, alu_B);
    end

    typedef struct {
        bit          valid;
        int          owner;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          g;       // grant edge
        int          res_e;   // edge at which result is written
        int          resp_e;  // edge at which done pulses
        int          lat;
        bit          tmo;
    } txn_t;

    txn_t        tx;
    int          m_last;
    logic [15:0] m_result, m_A, m_B;
    logic [1:0]  m_op;

    int n;
    int vectors;
    int miscompares;
    int forced_lat;
    bit hold_reqs;
    bit spur_en;
    bit force_md;

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, n, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        tx.valid = 1'b0;
        m_last   = 1;
        m_result = 16'h0000;
        m_A      = 16'h0000;
        m_B      = 16'h0000;
        m_op     = 2'b00;
    endtask

    task automatic compare_outputs();
        bit cur_g, cur_resp;
        cur_g    = tx.valid && n == tx.g;
        cur_resp = tx.valid && n == tx.resp_e;
        check1("gnt0", gnt0, cur_g && tx.owner == 0);
        check1("gnt1", gnt1, cur_g && tx.owner == 1);
        check1("done0", done0, cur_resp && tx.owner == 0);
        check1("done1", done1, cur_resp && tx.owner == 1);
        check1("err", err, cur_resp && tx.tmo);
        check1("busy", busy, tx.valid && n >= tx.g && n < tx.resp_e);
        check1("mul_start", mul_start, tx.valid && tx.op == 2'd2 && n == tx.g + 1);
        check16("result", result, m_result);
        check16("alu_A", alu_A, m_A);
        check16("alu_B", alu_B, m_B);
        check16("alu_op", {14'b0, alu_op}, {14'b0, m_op});
    endtask

    // One clock: predict a grant for the coming edge, drive mul_done, then check the outputs after the edge.
    task automatic cycle();
        int  e, w;
        bit  in_wait;
        e = n + 1;
        if ((!tx.valid || e > tx.resp_e) && (rq[0] || rq[1])) begin
            w = (rq[0] && rq[1]) ? 1 - m_last : (rq[1] ? 1 : 0);
            tx.valid = 1'b1;
            tx.owner = w;
            tx.op    = rop[w];
            tx.a     = (rop[w] == 2'd2) ? {8'h00, ra[w][7:0]} : ra[w];
            tx.b     = (rop[w] == 2'd2) ? {8'h00, rb[w][7:0]} : rb[w];
            tx.g     = e;
            tx.tmo   = 1'b0;
            tx.lat   = 0;
            if (rop[w] != 2'd2) begin
                tx.res_e = e + 1;
            end else begin
                tx.lat = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 20));
                if (tx.lat <= TA) begin
                    tx.res_e = e + 1 + tx.lat;
                end else begin
                    tx.res_e = e + 1 + TA;
                    tx.tmo   = 1'b1;
                end
            end
            tx.resp_e = tx.res_e + 1;
        end
        in_wait = tx.valid && tx.op == 2'd2 && e >= tx.g + 2 && e <= tx.res_e;
        if (force_md)     mul_done = 1'b1;
        else if (in_wait) mul_done = (e == tx.g + 1 + tx.lat);
        else              mul_done = spur_en && ($urandom_range(0, 7) == 0);
        noise = 16'($urandom);
        @(posedge Clk);
        n = e;
        #1;
        if (tx.valid && n == tx.g) begin
            m_op = tx.op;
            m_A  = tx.a;
            m_B  = tx.b;
            if (!hold_reqs) rq[tx.owner] = 1'b0;
        end
        if (tx.valid && n == tx.res_e) m_result = tx.tmo ? 16'h0000 : alu_fn(tx.op, tx.a, tx.b);
        if (tx.valid && n == tx.resp_e) m_last = tx.owner;
        compare_outputs();
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic do_reset();
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        t_req0 = 1'b0;
        mul_done = 1'b0;
        Rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(posedge Clk);
        n = n + 1;
        #1;
        Rst = 1'b0;
        compare_outputs();
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        rq[p]  = 1'b1;
        rop[p] = op;
        ra[p]  = a;
        rb[p]  = b;
    endtask

    initial begin
        n = 0; vectors = 0; miscompares = 0;
        forced_lat = 0; hold_reqs = 1'b0; spur_en = 1'b0; force_md = 1'b0;
        noise = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rop[p] = 2'b00; ra[p] = 16'h0000; rb[p] = 16'h0000;
        end
        t_req0 = 1'b0; t_op0 = 2'b00; t_a0 = 16'h0000; t_b0 = 16'h0000;
        t_mul_done = 1'b0; t_rout = 16'hBEEF;
        model_reset();
        #1;
        do_reset();
        check16("reset_result", result, 16'h0000);
        check1("reset_busy", busy, 1'b0);

        // ADD with operand capture; done two edges after the grant
        set_req(0, 2'd1, 16'h1234, 16'h0001);
        cycle();
        check1("add_gnt0", gnt0, 1'b1);
        cycle();
        check1("add_gnt0_pulse", gnt0, 1'b0);
        cycle();
        check1("add_done0", done0, 1'b1);
        check16("add_result", result, 16'h1235);
        cycle();

        // ADD wraps, NOT A
        set_req(0, 2'd1, 16'hFFFF, 16'h0002);
        cycles(3);
        check16("add_wrap", result, 16'h0001);
        cycle();
        set_req(0, 2'd3, 16'h00F0, 16'h1234);
        cycles(3);
        check16("not_a", result, 16'hFF0F);
        cycle();

        // MUL on port1 with an 11-cycle multiplier
        forced_lat = 11;
        set_req(1, 2'd2, 16'hFF07, 16'h0005);
        cycle();
        check1("mul_gnt1", gnt1, 1'b1);
        check16("mul_alu_A", alu_A, 16'h0007);
        check16("mul_alu_B", alu_B, 16'h0005);
        cycle();
        check1("mul_start_hi", mul_start, 1'b1);
        cycle();
        check1("mul_start_lo", mul_start, 1'b0);
        cycles(11);
        check1("mul_done1", done1, 1'b1);
        check16("mul_result", result, 16'h0023);
        check1("mul_err", err, 1'b0);
        forced_lat = 0;
        cycle();

        // tie: port0 first after reset, then strict alternation
        do_reset();
        hold_reqs = 1'b1;
        set_req(0, 2'd0, 16'h0F00, 16'h00F0);
        set_req(1, 2'd0, 16'h0F00, 16'h00F0);
        cycle();
        check1("rr_first_gnt0", gnt0, 1'b1);
        check1("rr_first_gnt1", gnt1, 1'b0);
        cycles(3);
        check1("rr_second_gnt1", gnt1, 1'b1);
        check1("rr_second_gnt0", gnt0, 1'b0);
        cycles(3);
        check1("rr_third_gnt0", gnt0, 1'b1);
        hold_reqs = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        cycles(3);

        // reset in the middle of a multiply; a late mul_done must be ignored
        forced_lat = 100;
        set_req(0, 2'd2, 16'h1234, 16'h0003);
        cycles(5);
        forced_lat = 0;
        #3;
        Rst = 1'b1;
        rq[0] = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        check1("async_rst_busy", busy, 1'b0);
        check16("async_rst_alu_A", alu_A, 16'h0000);
        @(posedge Clk);
        n = n + 1;
        #1;
        Rst = 1'b0;
        compare_outputs();
        force_md = 1'b1;
        cycle();
        force_md = 1'b0;
        cycles(4);
        check1("late_md_no_done", done0, 1'b0);

        // timeout path on the short-timeout instance
        t_req0 = 1'b1; t_op0 = 2'd0; t_a0 = 16'h0001; t_b0 = 16'h0002;
        cycle();
        check1("t_or_gnt0", t_gnt0, 1'b1);
        t_req0 = 1'b0;
        cycles(2);
        check1("t_or_done0", t_done0, 1'b1);
        check16("t_or_result", t_result, 16'hBEEF);
        cycle();
        t_req0 = 1'b1; t_op0 = 2'd2; t_a0 = 16'h0003; t_b0 = 16'h0004;
        cycle();
        check1("t_mul_gnt0", t_gnt0, 1'b1);
        t_req0 = 1'b0;
        cycle();
        check1("t_mul_start", t_mul_start, 1'b1);
        cycles(8);
        check1("t_pre_done0", t_done0, 1'b0);
        check1("t_pre_err", t_err, 1'b0);
        check1("t_pre_busy", t_busy, 1'b1);
        check16("t_pre_result", t_result, 16'h0000);
        cycle();
        check1("t_tmo_done0", t_done0, 1'b1);
        check1("t_tmo_err", t_err, 1'b1);
        check16("t_tmo_result", t_result, 16'h0000);
        check1("t_tmo_busy", t_busy, 1'b0);
        cycle();
        check1("t_after_done0", t_done0, 1'b0);
        check1("t_after_err", t_err, 1'b0);
        check1("t_after_busy", t_busy, 1'b0);

        // randomized traffic with drops and stray mul_done pulses
        spur_en = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (rq[p]) begin
                    if ($urandom_range(0, 23) == 0) rq[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(p, 2'($urandom), 16'($urandom), 16'($urandom));
                end
            end
            cycle();
        end
        spur_en = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        cycles(2 * TA + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
